// File: rtl/mips_rf_pkg.sv
// Shared defaults for the MIPS register file with load-use scoreboard.
package mips_rf_pkg;
  localparam int RF_DW       = 32;
  localparam int RF_AW       = 5;
  localparam int RF_ZERO_REG = 1;
  localparam int NREGS       = 2**RF_AW;
endpackage

// File: rtl/reg_pend_scoreboard.sv
// Per-register pending bits for outstanding loads, with two bypass-aware lookups.
module reg_pend_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_mark_en,
  input  logic [AW-1:0] i_mark_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_s_addr,
  input  logic [AW-1:0] i_t_addr,
  output logic          o_s_pend,
  output logic          o_t_pend
);
  localparam int NR = 2**AW;

  logic [NR-1:0] r_pend;
  logic          w_mark_ok;

  assign w_mark_ok = i_mark_en && !(ZERO_REG != 0 && i_mark_addr == '0);

  // Mark beats clear so back-to-back loads to one register stay pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (w_mark_ok && i_mark_addr == AW'(i))
          r_pend[i] <= 1'b1;
        else if (i_clr_en && i_clr_addr == AW'(i))
          r_pend[i] <= 1'b0;
      end
    end
  end

  // Load data arriving this cycle is bypassed, so the reader need not stall.
  assign o_s_pend = r_pend[i_s_addr] && !(i_clr_en && i_clr_addr == i_s_addr);
  assign o_t_pend = r_pend[i_t_addr] && !(i_clr_en && i_clr_addr == i_t_addr);
endmodule

// File: rtl/reg_file_scoreboard.sv
// Two-write / two-read MIPS register file with write bypass, load scoreboard
// and a registered write-collision flag.
module reg_file_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic          mark_en,
  input  logic [AW-1:0] mark_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] t_addr,
  output logic [DW-1:0] s_out,
  output logic [DW-1:0] t_out,
  output logic          s_pend,
  output logic          t_pend,
  output logic          err_collide
);
  localparam int NR = 2**AW;

  logic [NR-1:0][DW-1:0] r_regs;
  logic                  r_collide;
  logic                  w_wr0, w_wr1, w_collide;
  logic [DW-1:0]         w_s_out, w_t_out;

  assign w_wr0     = we0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign w_wr1     = we1 && !(ZERO_REG != 0 && waddr1 == '0);
  assign w_collide = w_wr0 && w_wr1 && waddr0 == waddr1;

  // Port 0 has priority, which drops port 1 data on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs    <= '0;
      r_collide <= 1'b0;
    end else begin
      r_collide <= w_collide;
      for (int i = 0; i < NR; i++) begin
        if (w_wr0 && waddr0 == AW'(i))
          r_regs[i] <= wdata0;
        else if (w_wr1 && waddr1 == AW'(i))
          r_regs[i] <= wdata1;
      end
    end
  end

  always_comb begin
    w_s_out = r_regs[s_addr];
    if (we1 && waddr1 == s_addr) w_s_out = wdata1;
    if (we0 && waddr0 == s_addr) w_s_out = wdata0;
    if (ZERO_REG != 0 && s_addr == '0) w_s_out = '0;
    w_t_out = r_regs[t_addr];
    if (we1 && waddr1 == t_addr) w_t_out = wdata1;
    if (we0 && waddr0 == t_addr) w_t_out = wdata0;
    if (ZERO_REG != 0 && t_addr == '0) w_t_out = '0;
  end

  assign s_out       = w_s_out;
  assign t_out       = w_t_out;
  assign err_collide = r_collide;

  reg_pend_scoreboard #(.AW(AW), .ZERO_REG(ZERO_REG)) u_pend (
    .clk        (clk),
    .reset      (reset),
    .i_mark_en  (mark_en),
    .i_mark_addr(mark_addr),
    .i_clr_en   (we1),
    .i_clr_addr (waddr1),
    .i_s_addr   (s_addr),
    .i_t_addr   (t_addr),
    .o_s_pend   (s_pend),
    .o_t_pend   (t_pend)
  );
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the 32x32 datapath register file for the pipelined MIPS core.
- Two write ports: port 0 is ALU write-back; port 1 is load/memory write-back.
- Two combinational read ports (S, T) with same-cycle write-to-read bypass.
- Per-register pending scoreboard so decode can detect load-use hazards; a registered flag reports write-port address collisions.

Parameters:
- DW, 32, data width of each register
- AW, 5, address width; depth NREGS = 2**AW
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never pending

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0 (ALU)
- waddr0  in  AW  write address, port 0
- wdata0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (load); also clears pending
- waddr1  in  AW  write address, port 1
- wdata1  in  DW  write data, port 1
- mark_en  in  1  set pending bit at mark_addr (load issued)
- mark_addr  in  AW  register to mark pending
- s_addr  in  AW  S read address
- t_addr  in  AW  T read address
- s_out  out  DW  S read data
- t_out  out  DW  T read data
- s_pend  out  1  S register pending
- t_pend  out  1  T register pending
- err_collide  out  1  registered pulse: both ports wrote the same address

Behaviour:
- Reset (async, active-high): all NREGS registers clear to 0, all pending bits clear to 0, err_collide clears to 0.
  - Reset asserted mid-operation discards writes and marks in that cycle.
  - Outputs during reset are derived from cleared state: s_out and t_out read 0 unless bypass is active on the current inputs.
- Writes take effect at posedge clk when weN=1.
  - Address 0 is ignored when ZERO_REG=1.
  - Write latency is 1 cycle, but reads see the data in the same cycle via bypass.
- Write collision (we0 and we1 both 1, waddr0==waddr1, address not a suppressed r0): port 0 data is written and port 1 data is dropped.
  - err_collide=1 for exactly the next cycle.
  - The pending bit is still cleared by port 1.
- Read S (T identical), combinational, in priority order:
  1. ZERO_REG and s_addr==0 -> 0.
  2. we0 and waddr0==s_addr -> wdata0.
  3. we1 and waddr1==s_addr -> wdata1.
  4. Otherwise the stored register value.
- Pending scoreboard, one bit per register, updated at posedge:
  - mark_en sets pend[mark_addr].
  - we1 clears pend[waddr1].
  - we0 does not affect pending.
  - Same address marked and cleared in one cycle: the mark wins and the bit ends at 1 (back-to-back loads to the same register).
  - ZERO_REG=1: marks to r0 are ignored and pend[0] is always 0.
- s_pend (t_pend identical), combinational:
  - Equals pend[s_addr], except 0 when we1 and waddr1==s_addr in the current cycle (bypassed load data is valid).
  - A same-cycle mark is not visible until the next cycle.
- No internal FSM beyond the storage arrays and the 1-bit collision register.
- Width rules: addresses are unsigned; no truncation, since NREGS = 2**AW exactly.

Decomposition:
- Shared package mips_rf_pkg holds the DW and AW defaults, the ZERO_REG default, and the localparam NREGS.
- One natural sub-module, reg_pend_scoreboard:
  - Holds the pending vector with its set/clear priority and the read-side bypass mask.
  - Instantiated once, with two lookup ports.
- Data array, write-collision logic and data bypass live in the top module.

Test Plan:
1. Reset mid-run after writing 0xDEADBEEF to r5 -> s_addr=5 reads 0; s_pend=0; err_collide=0, all while reset is high and after it is released.
2. Write bypass: we0=1, waddr0=7, wdata0=0x12345678, s_addr=t_addr=7 in the same cycle -> s_out=t_out=0x12345678 that cycle and the next (stored).
3. r0 protection: we0=1, waddr0=0, wdata0=0xFFFFFFFF; mark_en=1, mark_addr=0 -> s_addr=0 reads 0 and s_pend=0 forever.
4. Collision: we0 writes 0xAAAA0000 and we1 writes 0x5555FFFF, both to r9 -> r9=0xAAAA0000; err_collide=1 for exactly one cycle, then 0.
5. Scoreboard:
   - Cycle 0: mark r3 -> cycle 1: t_pend=1 with t_addr=3.
   - Cycle 2: we1 to r3 with 0x00000042 -> same cycle t_pend=0 and t_out=0x42; the bit stays clear afterwards.
6. Mark/clear race: r4 pending; in one cycle mark_en to r4 and we1 to r4 -> s_pend=0 that cycle (bypass), s_pend=1 on the next cycle.
